alu_req_sched: RTL
==================

// Module: alu_req_sched
// PURPOSE
//  Shares one 8-bit combinational ALU (5-bit opcode, cin; result/cout/z/v) among NREQ requesters.
//  Round-robin arbitration, one operation in flight, operands registered toward the ALU.
//  Outputs registered toward a single response port with a valid/ready handshake.
//  Sits between the requesting engines and the ALU instance; the ALU is instantiated outside this block.
// PARAMETERS
//  NREQ   4    number of requesters (2..8); IDW = $clog2(NREQ) is a localparam
// PORTS
//  clk          in   1         single clock, rising edge
//  rst_n        in   1         asynchronous, active-low reset
//  req_valid    in   NREQ      per-requester request valid
//  req_ready    out  NREQ      per-requester accept (one-hot or zero)
//  req_opcode   in   NREQ*5    flattened opcodes, requester i at [5i+4:5i]
//  req_a        in   NREQ*8    flattened operand A
//  req_b        in   NREQ*8    flattened operand B
//  req_cin      in   NREQ      per-requester carry-in
//  alu_opcode   out  5         to ALU
//  alu_a        out  8         to ALU
//  alu_b        out  8         to ALU
//  alu_cin      out  1         to ALU
//  alu_result   in   8         from ALU
//  alu_cout     in   1         from ALU
//  alu_z        in   1         from ALU
//  alu_v        in   1         from ALU
//  rsp_valid    out  1         response valid
//  rsp_ready    in   1         response accept
//  rsp_id       out  IDW       index of the requester being answered
//  rsp_result   out  8         captured result
//  rsp_flags    out  4         {err, v, z, cout}
// BEHAVIOUR
//  - FSM states: IDLE -> EXEC -> RESP -> IDLE.
//  - Reset values: state IDLE, rr pointer 0, every output 0 (rsp_valid=0, req_ready=0, alu_* = 0).
//  - IDLE
//    - req_ready is combinational: one-hot for the first valid requester at or after the pointer, wrapping.
//    - On handshake: latch opcode/a/b/cin into the ALU-side registers; pointer <= grant+1 mod NREQ.
//    - Next state is EXEC, or RESP with err=1 when opcode > 26.
//  - EXEC (1 cycle)
//    - alu_* hold the latched values.
//    - At the cycle end, capture alu_result/cout/z/v into the rsp registers; next state RESP.
//  - RESP
//    - rsp_valid=1; rsp_* hold stable until rsp_valid&rsp_ready, then go to IDLE.
//    - req_ready=0 in EXEC and RESP.
//  - Latency: handshake at edge N gives rsp_valid at edge N+2; illegal opcode gives rsp_valid at N+1.
//  - Throughput: at most one op per 3 cycles.
//  - Illegal opcode: ALU not sequenced, alu_* unchanged, result 0, flags = 4'b1000.
//  - Simultaneous requests resolve strictly by the rr pointer; a non-granted req_valid must stay asserted and is not dropped.
//  - A requester that deasserts req_valid before its grant is simply skipped.
//  - rsp_ready held at 0 stalls indefinitely with no loss of data.
//  - Reset mid-operation: the in-flight op is discarded silently and no response is issued.
// CONFIGURATION
//  ALU_CARRY_CHAIN_EN defined:
//    - Per-requester carry register, reset 0, written with alu_cout on every completed EXEC of that requester.
//    - Opcodes 2 and 3 take alu_cin from that register; req_cin is ignored for them.
//  Not defined: alu_cin = req_cin always; no carry registers are instantiated.
// STRUCTURE
//  - Package alu_pkg:
//    - opcode localparams OP_ADD=0 .. OP_RRC=26, and OP_MAX=26
//    - flag bit indices F_COUT=0, F_Z=1, F_V=2, F_ERR=3
//    - FSM state enum {S_IDLE, S_EXEC, S_RESP}
//  - Sub-module alu_rr_arb: NREQ-wide round-robin arbiter (req, ptr -> one-hot grant, grant index).
// TESTING
//  - Single ADD: req0 op=0, a=8'h0F, b=8'h01, handshake at N -> rsp_valid at N+2, id=0, result=8'h10, flags=4'b0000.
//  - All 4 req_valid high from reset, rsp_ready=1 -> grants in order 0,1,2,3 and rsp_id sequence 0,1,2,3.
//    - Then only req2 valid -> granted next.
//  - rsp_ready=0 for 5 cycles after rsp_valid:
//    - rsp_* stable; req_ready stays 0 despite other valids.
//    - Response accepted on the 6th cycle.
//  - Illegal opcode 27 from req3 -> rsp_valid at N+1, id=3, result=0, flags=4'b1000, alu_* unchanged.
//  - Carry chain, req1: op=0, a=8'hFF, b=8'h01 -> result=0, flags=4'b0011; then op=2, a=0, b=0, cin=0.
//    - Second result is 8'h01 with ALU_CARRY_CHAIN_EN, 8'h00 without.
//  - rst_n low during EXEC -> all outputs 0 asynchronously; after release: IDLE, pointer 0, no stale rsp_valid.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU request scheduler: opcode map, flag bit positions, FSM states.
package alu_pkg;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_ADC  = 5'd2;
    localparam logic [4:0] OP_SBC  = 5'd3;
    localparam logic [4:0] OP_INC  = 5'd4;
    localparam logic [4:0] OP_DEC  = 5'd5;
    localparam logic [4:0] OP_NEG  = 5'd6;
    localparam logic [4:0] OP_CMP  = 5'd7;
    localparam logic [4:0] OP_AND  = 5'd8;
    localparam logic [4:0] OP_OR   = 5'd9;
    localparam logic [4:0] OP_XOR  = 5'd10;
    localparam logic [4:0] OP_NOT  = 5'd11;
    localparam logic [4:0] OP_NAND = 5'd12;
    localparam logic [4:0] OP_NOR  = 5'd13;
    localparam logic [4:0] OP_XNOR = 5'd14;
    localparam logic [4:0] OP_BIC  = 5'd15;
    localparam logic [4:0] OP_PASA = 5'd16;
    localparam logic [4:0] OP_PASB = 5'd17;
    localparam logic [4:0] OP_SHL  = 5'd18;
    localparam logic [4:0] OP_SHR  = 5'd19;
    localparam logic [4:0] OP_SAR  = 5'd20;
    localparam logic [4:0] OP_ROL  = 5'd21;
    localparam logic [4:0] OP_ROR  = 5'd22;
    localparam logic [4:0] OP_SWAP = 5'd23;
    localparam logic [4:0] OP_CLR  = 5'd24;
    localparam logic [4:0] OP_RLC  = 5'd25;
    localparam logic [4:0] OP_RRC  = 5'd26;
    localparam logic [4:0] OP_MAX  = 5'd26;

    localparam int F_COUT = 0;
    localparam int F_Z    = 1;
    localparam int F_V    = 2;
    localparam int F_ERR  = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_e;

endpackage

// File: rtl/alu_rr_arb.sv
// Round-robin arbiter: first asserted request at or after ptr_i, wrapping; one-hot grant plus index.
module alu_rr_arb #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  gnt_idx_o,
    output logic            gnt_vld_o
);

    int unsigned j;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        gnt_vld_o = 1'b0;
        j         = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            j = (32'(ptr_i) + i) % NREQ;
            if (!gnt_vld_o && req_i[j]) begin
                gnt_o[j]  = 1'b1;
                gnt_idx_o = IDW'(j);
                gnt_vld_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_req_sched.sv
// Shares one external 8-bit ALU among NREQ requesters with round-robin grant and a registered response port.
// Optional feature ALU_CARRY_CHAIN_EN: per-requester carry register feeding alu_cin for opcodes 2 and 3.
module alu_req_sched
    import alu_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*5-1:0] req_opcode,
    input  logic [NREQ*8-1:0] req_a,
    input  logic [NREQ*8-1:0] req_b,
    input  logic [NREQ-1:0]   req_cin,
    output logic [4:0]        alu_opcode,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    output logic              alu_cin,
    input  logic [7:0]        alu_result,
    input  logic              alu_cout,
    input  logic              alu_z,
    input  logic              alu_v,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [7:0]        rsp_result,
    output logic [3:0]        rsp_flags
);

    state_e          state_q;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gnt_idx;
    logic            gnt_vld;
    logic            hs;
    logic [4:0]      sel_op;
    logic [7:0]      sel_a, sel_b;
    logic            sel_cin;
    logic [3:0]      exec_flags;

    logic [4:0]      alu_opcode_q;
    logic [7:0]      alu_a_q, alu_b_q;
    logic            alu_cin_q;
    logic            rsp_valid_q;
    logic [IDW-1:0]  rsp_id_q;
    logic [7:0]      rsp_result_q;
    logic [3:0]      rsp_flags_q;

    alu_rr_arb #(.NREQ(NREQ)) u_arb (
        .req_i     (req_valid),
        .ptr_i     (ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .gnt_vld_o (gnt_vld)
    );

    // Gated with rst_n so every output is 0 while reset is held, even with requests pending.
    assign req_ready = (rst_n && state_q == S_IDLE) ? gnt : '0;
    assign hs        = gnt_vld && (state_q == S_IDLE);

    assign sel_op = req_opcode[5*gnt_idx +: 5];
    assign sel_a  = req_a[8*gnt_idx +: 8];
    assign sel_b  = req_b[8*gnt_idx +: 8];
    assign ptr_d  = (32'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + IDW'(1);

`ifdef ALU_CARRY_CHAIN_EN
    logic [NREQ-1:0] carry_q;

    assign sel_cin = (sel_op == OP_ADC || sel_op == OP_SBC) ? carry_q[gnt_idx] : req_cin[gnt_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= '0;
        end else if (state_q == S_EXEC) begin
            carry_q[rsp_id_q] <= alu_cout;
        end
    end
`else
    assign sel_cin = req_cin[gnt_idx];
`endif

    always_comb begin
        exec_flags         = '0;
        exec_flags[F_COUT] = alu_cout;
        exec_flags[F_Z]    = alu_z;
        exec_flags[F_V]    = alu_v;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            alu_opcode_q <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_cin_q    <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (hs) begin
                    ptr_q    <= ptr_d;
                    rsp_id_q <= gnt_idx;
                    if (sel_op > OP_MAX) begin
                        // Illegal opcode: skip the ALU entirely, answer with the error flag only.
                        rsp_result_q       <= '0;
                        rsp_flags_q        <= '0;
                        rsp_flags_q[F_ERR] <= 1'b1;
                        rsp_valid_q        <= 1'b1;
                        state_q            <= S_RESP;
                    end else begin
                        alu_opcode_q <= sel_op;
                        alu_a_q      <= sel_a;
                        alu_b_q      <= sel_b;
                        alu_cin_q    <= sel_cin;
                        state_q      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    rsp_result_q <= alu_result;
                    rsp_flags_q  <= exec_flags;
                    rsp_valid_q  <= 1'b1;
                    state_q      <= S_RESP;
                end
                S_RESP: if (rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign alu_opcode = alu_opcode_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_cin    = alu_cin_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;

endmodule
